// File: rtl/wave_sequencer.sv
// wave_sequencer: paces game waves (countdown, active spawning, intermission) with a spawn request/ack handshake.
// Optional macro WAVE_SEQ_SPEEDUP_EN shortens the spawn period by PERIOD_STEP each wave, floored at SPAWN_PERIOD_MIN.
module wave_sequencer #(
  parameter int COUNTDOWN_TICKS    = 180,
  parameter int INTERMISSION_TICKS = 120,
  parameter int SPAWNS_PER_WAVE    = 8,
  parameter int SPAWN_PERIOD_INIT  = 60,
  parameter int SPAWN_PERIOD_MIN   = 12,
  parameter int PERIOD_STEP        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       enemies_alive,
  input  logic       spawn_ack,
  output logic       spawn_req,
  output logic       wave_start,
  output logic [7:0] wave_num,
  output logic [1:0] state
);

  // Counter width covers every value a tick counter or the period can hold.
  localparam int MAX_A   = (COUNTDOWN_TICKS > INTERMISSION_TICKS) ? COUNTDOWN_TICKS : INTERMISSION_TICKS;
  localparam int MAX_B   = (SPAWN_PERIOD_INIT > SPAWN_PERIOD_MIN + PERIOD_STEP) ?
                           SPAWN_PERIOD_INIT : SPAWN_PERIOD_MIN + PERIOD_STEP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(SPAWNS_PER_WAVE + 1);

  localparam logic [CW-1:0] CD_LAST = CW'(COUNTDOWN_TICKS - 1);
  localparam logic [CW-1:0] IM_LAST = CW'(INTERMISSION_TICKS - 1);
  localparam logic [CW-1:0] P_INIT  = CW'(SPAWN_PERIOD_INIT);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [SW-1:0] SPW     = SW'(SPAWNS_PER_WAVE);
  localparam logic [SW-1:0] S_ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COUNTDOWN    = 2'd1,
    ACTIVE       = 2'd2,
    INTERMISSION = 2'd3
  } state_t;

`ifdef WAVE_SEQ_SPEEDUP_EN
  localparam logic [CW-1:0] P_MIN  = CW'(SPAWN_PERIOD_MIN);
  localparam logic [CW-1:0] P_STEP = CW'(PERIOD_STEP);

  function automatic logic [CW-1:0] faster_period(input logic [CW-1:0] p);
    if (p >= P_MIN + P_STEP) begin
      return p - P_STEP;
    end else begin
      return P_MIN;
    end
  endfunction
`endif

  state_t        state_r, state_s;
  logic [CW-1:0] tick_cnt_r, tick_cnt_s;
  logic [CW-1:0] timer_r, timer_s;
  logic [CW-1:0] period_r, period_s;
  logic [SW-1:0] spawn_cnt_r, spawn_cnt_s;
  logic          spawn_req_r, spawn_req_s;
  logic          wave_start_r, wave_start_s;
  logic [7:0]    wave_num_r, wave_num_s;
  logic          qual_s;

  assign qual_s     = game_tick & ~pause;
  assign spawn_req  = spawn_req_r;
  assign wave_start = wave_start_r;
  assign wave_num   = wave_num_r;
  assign state      = state_r;

  // State and datapath registers; reset restores the idle configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      tick_cnt_r   <= '0;
      timer_r      <= '0;
      period_r     <= P_INIT;
      spawn_cnt_r  <= '0;
      spawn_req_r  <= 1'b0;
      wave_start_r <= 1'b0;
      wave_num_r   <= 8'd0;
    end else begin
      state_r      <= state_s;
      tick_cnt_r   <= tick_cnt_s;
      timer_r      <= timer_s;
      period_r     <= period_s;
      spawn_cnt_r  <= spawn_cnt_s;
      spawn_req_r  <= spawn_req_s;
      wave_start_r <= wave_start_s;
      wave_num_r   <= wave_num_s;
    end
  end

  // Next-state and next-output logic; game_over outranks every other control.
  always_comb begin
    state_s      = state_r;
    tick_cnt_s   = tick_cnt_r;
    timer_s      = timer_r;
    period_s     = period_r;
    spawn_cnt_s  = spawn_cnt_r;
    spawn_req_s  = spawn_req_r;
    wave_start_s = 1'b0;
    wave_num_s   = wave_num_r;

    if (game_over) begin
      state_s     = IDLE;
      tick_cnt_s  = '0;
      timer_s     = '0;
      spawn_cnt_s = '0;
      spawn_req_s = 1'b0;
      wave_num_s  = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s    = COUNTDOWN;
            tick_cnt_s = '0;
            wave_num_s = 8'd1;
            period_s   = P_INIT;
          end else begin
            state_s = IDLE;
          end
        end
        COUNTDOWN, INTERMISSION: begin
          if (qual_s) begin
            if (tick_cnt_r == ((state_r == COUNTDOWN) ? CD_LAST : IM_LAST)) begin
              state_s      = ACTIVE;
              tick_cnt_s   = '0;
              wave_start_s = 1'b1;
              spawn_cnt_s  = '0;
              timer_s      = period_r;
            end else begin
              tick_cnt_s = tick_cnt_r + C_ONE;
            end
          end else begin
            tick_cnt_s = tick_cnt_r;
          end
        end
        ACTIVE: begin
          // The timer is frozen while a request is outstanding.
          if (spawn_req_r) begin
            if (spawn_ack) begin
              spawn_req_s = 1'b0;
              spawn_cnt_s = spawn_cnt_r + S_ONE;
              timer_s     = period_r;
            end else begin
              spawn_req_s = 1'b1;
            end
          end else if ((spawn_cnt_r == SPW) && !enemies_alive) begin
            state_s    = INTERMISSION;
            tick_cnt_s = '0;
            wave_num_s = (wave_num_r == 8'd255) ? 8'd255 : wave_num_r + 8'd1;
`ifdef WAVE_SEQ_SPEEDUP_EN
            period_s   = faster_period(period_r);
`else
            period_s   = period_r;
`endif
          end else if (qual_s && (spawn_cnt_r < SPW)) begin
            if (timer_r <= C_ONE) begin
              timer_s     = '0;
              spawn_req_s = 1'b1;
            end else begin
              timer_s = timer_r - C_ONE;
            end
          end else begin
            timer_s = timer_r;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter COUNTDOWN_TICKS, default 180, meaning qualifying ticks spent in COUNTDOWN before the first wave.
REQ-002 SHALL have parameter INTERMISSION_TICKS, default 120, meaning qualifying ticks between waves.
REQ-003 SHALL have parameter SPAWNS_PER_WAVE, default 8, meaning spawn requests issued per wave.
REQ-004 SHALL have parameter SPAWN_PERIOD_INIT, default 60, meaning qualifying ticks between spawns in wave 1.
REQ-005 SHALL have parameter SPAWN_PERIOD_MIN, default 12, meaning the floor for the spawn period.
REQ-006 SHALL have parameter PERIOD_STEP, default 4, meaning the per-wave spawn period reduction.
REQ-007 SHALL have port clock, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-009 SHALL have port game_tick, input, 1, meaning a one-cycle frame pulse from the gameClock block.
REQ-010 SHALL have ports start, pause, game_over, input, 1 each, meaning level controls from the game FSM.
REQ-011 SHALL have port enemies_alive, input, 1, meaning at least one enemy is still on screen.
REQ-012 SHALL have port spawn_ack, input, 1, meaning the spawner accepted the pending request.
REQ-013 SHALL have port spawn_req, output, 1, meaning a spawn request held until acknowledged.
REQ-014 SHALL have port wave_start, output, 1, meaning a one-cycle pulse on each ACTIVE entry.
REQ-015 SHALL have port wave_num, output, 8, meaning the current wave number; port state, output, 2, meaning IDLE=0, COUNTDOWN=1, ACTIVE=2, INTERMISSION=3.

Function
REQ-016 A qualifying tick SHALL be a cycle with game_tick=1 and pause=0; tick counters SHALL change only on qualifying ticks.
REQ-017 In IDLE, start=1 and game_over=0 SHALL move to COUNTDOWN next edge, set wave_num=1 and period=SPAWN_PERIOD_INIT; start SHALL be ignored outside IDLE.
REQ-018 COUNTDOWN and INTERMISSION SHALL leave exactly on the Nth qualifying tick after entry (N=COUNTDOWN_TICKS or INTERMISSION_TICKS) and enter ACTIVE at the following edge.
REQ-019 On ACTIVE entry, wave_start SHALL pulse for one cycle, spawn count SHALL clear, and the spawn timer SHALL load the current period.
REQ-020 In ACTIVE, spawn_req SHALL rise on the edge after the qualifying tick that expires the timer, provided spawn count < SPAWNS_PER_WAVE.
REQ-021 spawn_req SHALL stay high until sampled with spawn_ack=1, then drop the next edge; the spawn count SHALL increment and the timer SHALL reload on that edge.
REQ-022 The spawn timer SHALL hold while spawn_req is high; spawn_ack with spawn_req low SHALL be ignored.
REQ-023 pause SHALL NOT block handshake completion.
REQ-024 ACTIVE SHALL go to INTERMISSION when spawn count = SPAWNS_PER_WAVE, spawn_req=0, and enemies_alive=0.
REQ-025 On INTERMISSION entry, wave_num SHALL increment, saturating at 255.
REQ-026 game_over=1 SHALL force IDLE at the next edge from any state, clear spawn_req and wave_num, and override start in the same cycle.

Reset
REQ-027 Asserting reset SHALL immediately set state=IDLE, spawn_req=0, wave_start=0, wave_num=0, all counters=0, and period=SPAWN_PERIOD_INIT, regardless of clock, including mid-handshake.
REQ-028 After reset release, the block SHALL stay in IDLE until start.

Configuration
REQ-029 With macro WAVE_SEQ_SPEEDUP_EN defined, on each INTERMISSION entry period SHALL become max(period-PERIOD_STEP, SPAWN_PERIOD_MIN) without underflow.
REQ-030 Without WAVE_SEQ_SPEEDUP_EN, period SHALL remain SPAWN_PERIOD_INIT for all waves and the subtract/compare logic SHALL be absent.

Verification (COUNTDOWN_TICKS=3, INTERMISSION_TICKS=2, SPAWNS_PER_WAVE=2, SPAWN_PERIOD_INIT=4, SPAWN_PERIOD_MIN=2, PERIOD_STEP=1, game_tick every 5 clocks)
REQ-031 Basic wave: start -> state=1, then 3 ticks later state=2, wave_start pulse, wave_num=1; spawn_req 4 ticks later; ack immediately, 2 spawns total.
REQ-032 Stalled ack: withhold spawn_ack 20 clocks -> spawn_req stays high, timer frozen, no second request until ack + 4 ticks.
REQ-033 Wave end: 2 spawns acked with enemies_alive=1 -> stay ACTIVE; drop enemies_alive -> state=3, wave_num=2; after 2 ticks -> ACTIVE.
REQ-034 Speedup: with WAVE_SEQ_SPEEDUP_EN, spawn intervals SHALL be 4, 3, 2, 2 ticks in waves 1 to 4; without the macro, 4 ticks in every wave.
REQ-035 Pause plus game_over: pause for 10 ticks in COUNTDOWN -> no progress; game_over with spawn_req high -> IDLE, spawn_req=0, wave_num=0 next edge; async reset mid-wave -> outputs clear without a clock edge.
